mc_control_fsm: RTL and testbench

Multicycle control sequencer for the RV32I core datapath. It drives the 3-input result select (ALU out / read data / ALU result), the ALU operand selects, and the PC, IR and register-file write enables. It also manages the unified memory request/ready handshake. One instruction executes over 3-5 states. A sticky trap is raised on an illegal opcode or on a memory timeout.

---
 rtl/mc_ctrl_pkg.sv | 60 ++++++
 rtl/mc_opcode_class.sv | 23 ++
 rtl/mc_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    JAL,
    BEQ,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that hold a memory request open and are subject to the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier feeding the DECODE transition.
module mc_opcode_class
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output op_class_t  op_class,
  output logic       illegal
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op)
      OP_LOAD, OP_STORE: op_class = CLS_MEM;
      OP_RTYPE:          op_class = CLS_RTYPE;
      OP_ITYPE:          op_class = CLS_ITYPE;
      OP_BEQ:            op_class = CLS_BRANCH;
      OP_JAL:            op_class = CLS_JUMP;
      default:           op_class = CLS_ILLEGAL;
    endcase
    illegal = (op_class == CLS_ILLEGAL);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: drives datapath selects/enables, the memory
// handshake, and a sticky trap on illegal opcode or memory timeout.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int unsigned CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t    state, next_state;
  logic [CW-1:0] tmo_cnt;
  logic [1:0]    cause_q, cause_d;
  op_class_t     op_class;
  logic          illegal;
  logic          waiting, tmo_hit;

  mc_opcode_class u_opcode_class (
    .op       (op),
    .op_class (op_class),
    .illegal  (illegal)
  );

  assign waiting    = is_mem_state(state) && !mem_ready;
  assign tmo_hit    = (MEM_TIMEOUT != 0) && waiting && (tmo_cnt == CW'(MEM_TIMEOUT));
  assign trap_cause = cause_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      tmo_cnt <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= next_state;
      cause_q <= cause_d;
      if ((next_state != state) && is_mem_state(next_state))
        tmo_cnt <= '0;
      else if (waiting && (tmo_cnt != '1))
        tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_comb begin
    next_state = state;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    trap       = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALU_ADD;
          result_src = RES_ALURESULT;
          next_state = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (illegal) begin
          next_state = TRAP;
          cause_d    = CAUSE_ILLEGAL;
        end else begin
          case (op_class)
            CLS_MEM:    next_state = MEMADR;
            CLS_RTYPE:  next_state = EXECR;
            CLS_ITYPE:  next_state = EXECI;
            CLS_BRANCH: next_state = BEQ;
            CLS_JUMP:   next_state = JAL;
            default:    next_state = TRAP;
          endcase
        end
      end
      MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end
      end
      EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_SUB;
        pc_write   = zero;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      TRAP: trap = 1'b1;
      default: next_state = FETCH;
    endcase

    // A ready in the final allowed cycle completes normally instead of trapping.
    if (tmo_hit) begin
      next_state = TRAP;
      cause_d    = CAUSE_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm (MEM_TIMEOUT = 4).
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       instr_done, trap;
  logic [1:0] trap_cause;

  int n_checks = 0;
  int n_fail   = 0;

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,result_src,
  //  alu_src_a,alu_src_b,alu_op,instr_done,trap,trap_cause}
  logic [17:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, instr_done, trap, trap_cause};

  localparam logic [17:0] V_FWAIT  = {6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_FRDY   = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_DECODE = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_MEMADR = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_MEMRD  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_MEMWB  = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] V_MWWAIT = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_MWRDY  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] V_EXECR  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_EXECI  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_ALUWB  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] V_JAL    = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00};
  localparam logic [17:0] V_BEQ_T  = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] V_BEQ_F  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00};
  localparam logic [17:0] V_TR_ILL = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01};
  localparam logic [17:0] V_TR_TO  = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10};

  localparam logic [6:0] C_LW  = 7'b0000011;
  localparam logic [6:0] C_SW  = 7'b0100011;
  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_I   = 7'b0010011;
  localparam logic [6:0] C_BEQ = 7'b1100011;
  localparam logic [6:0] C_JAL = 7'b1101111;
  localparam logic [6:0] C_BAD = 7'b1111111;

  mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  // Leaves the bench just after a negedge with the DUT in its first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_FWAIT) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", obs, V_FWAIT);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_FWAIT) begin
      n_fail++;
      $display("FAIL reset_first_fetch: got %b expected %b", obs, V_FWAIT);
    end
    @(negedge clk);
  endtask

  task automatic test_lw();
    logic [17:0] exp [6] = '{V_FRDY, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FRDY};
    do_reset();
    op = C_LW;
    zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL lw cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [17:0] exp [8] = '{V_FRDY, V_DECODE, V_MEMADR, V_MWWAIT, V_MWWAIT, V_MWWAIT, V_MWRDY, V_FWAIT};
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    op = C_SW;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL sw cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq(input logic z);
    logic [17:0] exp [4];
    exp = '{V_FRDY, V_DECODE, (z ? V_BEQ_T : V_BEQ_F), V_FRDY};
    do_reset();
    op = C_BEQ;
    zero = z;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL beq zero=%0b cycle %0d: got %b expected %b", z, i, obs, exp[i]);
      end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [17:0] exp [5] = '{V_FRDY, V_DECODE, V_JAL, V_ALUWB, V_FRDY};
    do_reset();
    op = C_JAL;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL jal cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp [9] = '{V_FRDY, V_DECODE, V_EXECI, V_ALUWB, V_FRDY, V_DECODE, V_EXECR, V_ALUWB, V_FRDY};
    logic [6:0]  ops [9] = '{C_I, C_I, C_I, C_I, C_R, C_R, C_R, C_R, C_R};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      op = ops[i];
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    op = C_BAD;
    for (int i = 0; i < 12; i++) begin
      logic [17:0] e;
      e = (i == 0) ? V_FRDY : (i == 1) ? V_DECODE : V_TR_ILL;
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL illegal cycle %0d: got %b expected %b", i, obs, e);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== V_FWAIT) begin
      n_fail++;
      $display("FAIL illegal_async_clear: got %b expected %b", obs, V_FWAIT);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    op = C_R;
    for (int i = 0; i < 8; i++) begin
      logic [17:0] e;
      e = (i < 5) ? V_FWAIT : V_TR_TO;
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout_ready_wins();
    logic [17:0] exp [7] = '{V_FWAIT, V_FWAIT, V_FWAIT, V_FWAIT, V_FRDY, V_DECODE, V_EXECR};
    logic        rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    op = C_R;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL timeout_ready cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_instr();
    logic [17:0] exp [5] = '{V_FRDY, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    do_reset();
    op = C_LW;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL midreset cycle %0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i < 4) @(negedge clk);
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== V_FWAIT) begin
      n_fail++;
      $display("FAIL midreset_abort: got %b expected %b", obs, V_FWAIT);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    op = 7'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_timeout_ready_wins();
    test_reset_mid_instr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
